// File: rtl/x_ramb_tdp_asym.sv
// x_ramb_tdp_asym: true-dual-port block RAM simulation model with one clock
// and independent port widths.
// Port A word a covers array bits [a*WIDTH_A +: WIDTH_A]. Port B word b covers
// array bits [b*WIDTH_B +: WIDTH_B].
// Each port has a read latch with selectable write mode, synchronous
// set/reset, and an optional output register (DO_REG_*) with its own clock
// enable.
// Optional feature: define RAM_COLLISION_CHECK_EN to add the COLL output and a
// message for every overlapping cross-port access that includes a write.
// Interface timing: there is no valid/ready handshake. A read issued with EN=1
// appears on DO one clock later (DO_REG=0) or two clocks later (DO_REG=1 with
// REGCE=1). The caller tracks this latency itself.
module x_ramb_tdp_asym #(
  parameter int                  MEM_BITS     = 16384,
  parameter int                  WIDTH_A      = 2,
  parameter int                  WIDTH_B      = 16,
  parameter string               WRITE_MODE_A = "WRITE_FIRST",
  parameter string               WRITE_MODE_B = "WRITE_FIRST",
  parameter bit                  DO_REG_A     = 1'b0,
  parameter bit                  DO_REG_B     = 1'b0,
  parameter logic [WIDTH_A-1:0]  INIT_A       = '0,
  parameter logic [WIDTH_B-1:0]  INIT_B       = '0,
  parameter logic [WIDTH_A-1:0]  SRVAL_A      = '0,
  parameter logic [WIDTH_B-1:0]  SRVAL_B      = '0,
  parameter logic [MEM_BITS-1:0] INIT_MEM     = '0,
  localparam int AW_A = (MEM_BITS / WIDTH_A > 1) ? $clog2(MEM_BITS / WIDTH_A) : 1,
  localparam int AW_B = (MEM_BITS / WIDTH_B > 1) ? $clog2(MEM_BITS / WIDTH_B) : 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               ENA,
  input  logic               WEA,
  input  logic               SSRA,
  input  logic               REGCEA,
  input  logic [AW_A-1:0]    ADDRA,
  input  logic [WIDTH_A-1:0] DIA,
  output logic [WIDTH_A-1:0] DOA,
  input  logic               ENB,
  input  logic               WEB,
  input  logic               SSRB,
  input  logic               REGCEB,
  input  logic [AW_B-1:0]    ADDRB,
  input  logic [WIDTH_B-1:0] DIB,
  output logic [WIDTH_B-1:0] DOB
`ifdef RAM_COLLISION_CHECK_EN
  ,
  output logic               COLL
`endif
);

  // Write-mode encoding: 0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE, 3 = illegal.
  localparam int MODE_A = (WRITE_MODE_A == "WRITE_FIRST") ? 0 :
                          (WRITE_MODE_A == "READ_FIRST")  ? 1 :
                          (WRITE_MODE_A == "NO_CHANGE")   ? 2 : 3;
  localparam int MODE_B = (WRITE_MODE_B == "WRITE_FIRST") ? 0 :
                          (WRITE_MODE_B == "READ_FIRST")  ? 1 :
                          (WRITE_MODE_B == "NO_CHANGE")   ? 2 : 3;

  localparam bit POW2_M = (MEM_BITS > 0) && ((MEM_BITS & (MEM_BITS - 1)) == 0);
  localparam bit POW2_A = (WIDTH_A > 0) && ((WIDTH_A & (WIDTH_A - 1)) == 0);
  localparam bit POW2_B = (WIDTH_B > 0) && ((WIDTH_B & (WIDTH_B - 1)) == 0);
  localparam bit GEOM_OK = POW2_M && POW2_A && POW2_B &&
                           (WIDTH_A <= MEM_BITS) && (WIDTH_B <= MEM_BITS);

  // Bad configurations stop elaboration instead of simulating garbage.
  if (MODE_A == 3 || MODE_B == 3) begin : g_bad_mode
    $fatal(1, "x_ramb_tdp_asym: illegal WRITE_MODE_A/WRITE_MODE_B string");
  end
  if (!GEOM_OK) begin : g_bad_geom
    $fatal(1, "x_ramb_tdp_asym: MEM_BITS/WIDTH_A/WIDTH_B must be powers of two with widths <= MEM_BITS");
  end

  // The bit offset of a word is its address shifted left by log2(width).
  // One spare bit keeps the 1-bit and full-width corner cases representable.
  localparam int LOG_A = $clog2(WIDTH_A);
  localparam int LOG_B = $clog2(WIDTH_B);
  localparam int BW    = $clog2(MEM_BITS) + 1;

  logic [BW-1:0]       base_a;
  logic [BW-1:0]       base_b;
  logic [WIDTH_A-1:0]  word_a;
  logic [WIDTH_B-1:0]  word_b;
  logic [WIDTH_A-1:0]  lat_a;
  logic [WIDTH_B-1:0]  lat_b;

  // The array is a simulation-model memory. Power-up contents come from
  // INIT_MEM, and RST_N never clears it.
  logic [MEM_BITS-1:0] mem = INIT_MEM;

  assign base_a = BW'(ADDRA) << LOG_A;
  assign base_b = BW'(ADDRB) << LOG_B;

  // Reads see the array as it was before this edge. Every read is therefore
  // read-before-write across ports.
  assign word_a = mem[base_a +: WIDTH_A];
  assign word_b = mem[base_b +: WIDTH_B];

  // Array writes. Port B's assignment comes last, so B wins on overlapping bits.
  always_ff @(posedge CLK) begin
    if (ENA && WEA) mem[base_a +: WIDTH_A] <= DIA;
    if (ENB && WEB) mem[base_b +: WIDTH_B] <= DIB;
  end

  // Port A read latch. SSR acts here only when there is no output register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lat_a <= INIT_A;
    end else if (ENA) begin
      if (SSRA && !DO_REG_A)  lat_a <= SRVAL_A;
      else if (!WEA)          lat_a <= word_a;
      else if (MODE_A == 0)   lat_a <= DIA;
      else if (MODE_A == 1)   lat_a <= word_a;
      // NO_CHANGE: the latch keeps its value during a write.
    end
  end

  // Port B read latch. Same rules as port A.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lat_b <= INIT_B;
    end else if (ENB) begin
      if (SSRB && !DO_REG_B)  lat_b <= SRVAL_B;
      else if (!WEB)          lat_b <= word_b;
      else if (MODE_B == 0)   lat_b <= DIB;
      else if (MODE_B == 1)   lat_b <= word_b;
    end
  end

  if (DO_REG_A) begin : g_doreg_a
    logic [WIDTH_A-1:0] do_a_q;
    // Port A output register. It loads the latch on REGCEA, and SSRA forces SRVAL_A.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)      do_a_q <= INIT_A;
      else if (REGCEA) do_a_q <= SSRA ? SRVAL_A : lat_a;
    end
    assign DOA = do_a_q;
  end else begin : g_nodoreg_a
    wire unused_regce_a = REGCEA;
    assign DOA = lat_a;
  end

  if (DO_REG_B) begin : g_doreg_b
    logic [WIDTH_B-1:0] do_b_q;
    // Port B output register. It loads the latch on REGCEB, and SSRB forces SRVAL_B.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)      do_b_q <= INIT_B;
      else if (REGCEB) do_b_q <= SSRB ? SRVAL_B : lat_b;
    end
    assign DOB = do_b_q;
  end else begin : g_nodoreg_b
    wire unused_regce_b = REGCEB;
    assign DOB = lat_b;
  end

`ifdef RAM_COLLISION_CHECK_EN
  localparam int EW = BW + 1;

  logic [EW-1:0] lo_a, hi_a, lo_b, hi_b;
  logic          overlap;
  logic          coll_ev;

  // Each word is the half-open bit range [lo, hi). Two words overlap when
  // each range starts before the other one ends.
  assign lo_a    = EW'(base_a);
  assign hi_a    = lo_a + EW'(WIDTH_A);
  assign lo_b    = EW'(base_b);
  assign hi_b    = lo_b + EW'(WIDTH_B);
  assign overlap = (lo_a < hi_b) && (lo_b < hi_a);
  assign coll_ev = ENA && ENB && (WEA || WEB) && overlap;

  // COLL is high for exactly the cycle after an overlapping access that includes a write.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) COLL <= 1'b0;
    else        COLL <= coll_ev;
  end

  // Report each collision event as it is registered.
  always_ff @(posedge CLK) begin
    if (RST_N && coll_ev)
      $display("%0t x_ramb_tdp_asym collision: ADDRA=%0h ADDRB=%0h", $time, ADDRA, ADDRB);
  end
`endif

endmodule

// File: tb/tb_x_ramb_tdp_asym.sv
// Testbench for x_ramb_tdp_asym. Four instances share one input stream and
// differ only in port B write mode or output register:
// - WRITE_FIRST
// - READ_FIRST
// - NO_CHANGE
// - WRITE_FIRST with DO_REG_B=1
// The driver pushes expected outputs tagged with the cycle they are due. A
// monitor pops and compares them on the falling edge.
module tb_x_ramb_tdp_asym;

  localparam logic [15:0] INIT_B_V  = 16'hA5A5;
  localparam logic [15:0] SRVAL_B_V = 16'h0F0F;
  localparam logic [1:0]  INIT_A_V  = 2'b01;
  localparam logic [1:0]  SRVAL_A_V = 2'b10;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  int   cyc = 0;

  initial forever #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- shared DUT inputs ----------------
  logic        ena, wea, ssra, regcea;
  logic [12:0] addra;
  logic [1:0]  dia;
  logic        enb, web, ssrb, regceb;
  logic [9:0]  addrb;
  logic [15:0] dib;

  logic [1:0]  doa0, doa_rf, doa_nc, doa_reg;
  logic [15:0] dob0, dob_rf, dob_nc, dob_reg;
`ifdef RAM_COLLISION_CHECK_EN
  logic        coll0, coll1, coll2, coll3;
`endif
  logic        coll_next = 1'b0;

  x_ramb_tdp_asym #(.WRITE_MODE_B("WRITE_FIRST"), .INIT_A(INIT_A_V), .INIT_B(INIT_B_V),
                    .SRVAL_A(SRVAL_A_V), .SRVAL_B(SRVAL_B_V)) dut0 (
    .CLK(CLK), .RST_N(RST_N),
    .ENA(ena), .WEA(wea), .SSRA(ssra), .REGCEA(regcea), .ADDRA(addra), .DIA(dia), .DOA(doa0),
    .ENB(enb), .WEB(web), .SSRB(ssrb), .REGCEB(regceb), .ADDRB(addrb), .DIB(dib), .DOB(dob0)
`ifdef RAM_COLLISION_CHECK_EN
    , .COLL(coll0)
`endif
  );

  x_ramb_tdp_asym #(.WRITE_MODE_B("READ_FIRST"), .INIT_A(INIT_A_V), .INIT_B(INIT_B_V),
                    .SRVAL_A(SRVAL_A_V), .SRVAL_B(SRVAL_B_V)) dut_rf (
    .CLK(CLK), .RST_N(RST_N),
    .ENA(ena), .WEA(wea), .SSRA(ssra), .REGCEA(regcea), .ADDRA(addra), .DIA(dia), .DOA(doa_rf),
    .ENB(enb), .WEB(web), .SSRB(ssrb), .REGCEB(regceb), .ADDRB(addrb), .DIB(dib), .DOB(dob_rf)
`ifdef RAM_COLLISION_CHECK_EN
    , .COLL(coll1)
`endif
  );

  x_ramb_tdp_asym #(.WRITE_MODE_B("NO_CHANGE"), .INIT_A(INIT_A_V), .INIT_B(INIT_B_V),
                    .SRVAL_A(SRVAL_A_V), .SRVAL_B(SRVAL_B_V)) dut_nc (
    .CLK(CLK), .RST_N(RST_N),
    .ENA(ena), .WEA(wea), .SSRA(ssra), .REGCEA(regcea), .ADDRA(addra), .DIA(dia), .DOA(doa_nc),
    .ENB(enb), .WEB(web), .SSRB(ssrb), .REGCEB(regceb), .ADDRB(addrb), .DIB(dib), .DOB(dob_nc)
`ifdef RAM_COLLISION_CHECK_EN
    , .COLL(coll2)
`endif
  );

  x_ramb_tdp_asym #(.DO_REG_B(1'b1), .INIT_A(INIT_A_V), .INIT_B(INIT_B_V),
                    .SRVAL_A(SRVAL_A_V), .SRVAL_B(SRVAL_B_V)) dut_reg (
    .CLK(CLK), .RST_N(RST_N),
    .ENA(ena), .WEA(wea), .SSRA(ssra), .REGCEA(regcea), .ADDRA(addra), .DIA(dia), .DOA(doa_reg),
    .ENB(enb), .WEB(web), .SSRB(ssrb), .REGCEB(regceb), .ADDRB(addrb), .DIB(dib), .DOB(dob_reg)
`ifdef RAM_COLLISION_CHECK_EN
    , .COLL(coll3)
`endif
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int          sel;
    int          due;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      0:       observe = {14'b0, doa0};
      1:       observe = dob0;
      2:       observe = dob_rf;
      3:       observe = dob_nc;
      4:       observe = dob_reg;
`ifdef RAM_COLLISION_CHECK_EN
      5:       observe = {12'b0, coll3, coll2, coll1, coll0};
`endif
      default: observe = 16'hxxxx;
    endcase
  endfunction

  task automatic push_exp(input int sel, input int lat, input logic [15:0] val, input string name);
    exp_t e;
    e.sel  = sel;
    e.due  = cyc + lat;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every expectation that falls due on this cycle.
  always @(negedge CLK) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].due == cyc) begin
        check(exp_q[i].name, observe(exp_q[i].sel), exp_q[i].val);
        exp_q.delete(i);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ea, input logic wa, input logic sa, input logic [12:0] aa,
                       input logic [1:0] da, input logic eb, input logic wb, input logic sb,
                       input logic rb, input logic [9:0] ab, input logic [15:0] db);
    ena = ea; wea = wa; ssra = sa; regcea = 1'b0; addra = aa; dia = da;
    enb = eb; web = wb; ssrb = sb; regceb = rb; addrb = ab; dib = db;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 13'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 16'd0);
  endtask

  // Advance one clock. With the collision option, every cycle also has a COLL expectation.
  task automatic tick();
`ifdef RAM_COLLISION_CHECK_EN
    push_exp(5, 1, coll_next ? 16'h000F : 16'h0000, "coll");
`endif
    coll_next = 1'b0;
    @(negedge CLK);
  endtask

  logic [1:0] wvals [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    idle();

    // Reset asserted mid-clock; outputs take INIT values immediately.
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("rst_dob",     dob0,    INIT_B_V);
    check("rst_dob_rf",  dob_rf,  INIT_B_V);
    check("rst_dob_nc",  dob_nc,  INIT_B_V);
    check("rst_dob_reg", dob_reg, INIT_B_V);
    check("rst_doa",     {14'b0, doa0},    {14'b0, INIT_A_V});
    check("rst_doa_rf",  {14'b0, doa_rf},  {14'b0, INIT_A_V});
    check("rst_doa_nc",  {14'b0, doa_nc},  {14'b0, INIT_A_V});
    check("rst_doa_reg", {14'b0, doa_reg}, {14'b0, INIT_A_V});
`ifdef RAM_COLLISION_CHECK_EN
    check("rst_coll", {12'b0, coll3, coll2, coll1, coll0}, 16'h0000);
`endif
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // Idle cycle after release: everything holds INIT.
    idle();
    push_exp(1, 1, INIT_B_V, "hold_dob");
    push_exp(4, 1, INIT_B_V, "hold_dob_reg");
    push_exp(0, 1, {14'b0, INIT_A_V}, "hold_doa");
    tick();

    // Width mapping: eight 2-bit A writes fill B word 0.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 1'b0, 13'(k), wvals[k], 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 16'd0);
      push_exp(0, 1, {14'b0, wvals[k]}, "wmap_doa_wf");
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 13'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 16'd0);
    push_exp(1, 1, 16'h3939, "map_b0");
    push_exp(2, 1, 16'h3939, "map_b0_rf");
    push_exp(3, 1, 16'h3939, "map_b0_nc");
    tick();

    // Write modes at B 0x10: first write 1234 over 0000, then 5678 over 1234.
    drive(1'b0, 1'b0, 1'b0, 13'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h010, 16'h1234);
    push_exp(1, 1, 16'h1234, "wf_1234");
    push_exp(2, 1, 16'h0000, "rf_old0");
    push_exp(3, 1, 16'h3939, "nc_hold1");
    tick();
    drive(1'b0, 1'b0, 1'b0, 13'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h010, 16'h5678);
    push_exp(1, 1, 16'h5678, "wf_5678");
    push_exp(2, 1, 16'h1234, "rf_1234");
    push_exp(3, 1, 16'h3939, "nc_hold2");
    tick();
    drive(1'b0, 1'b0, 1'b0, 13'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h010, 16'd0);
    push_exp(1, 1, 16'h5678, "rd10_wf");
    push_exp(2, 1, 16'h5678, "rd10_rf");
    push_exp(3, 1, 16'h5678, "rd10_nc");
    tick();

    // Output register on B.
    drive(1'b0, 1'b0, 1'b0, 13'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h020, 16'hBEEF);
    push_exp(1, 1, 16'hBEEF, "wr_beef");
    push_exp(4, 1, INIT_B_V, "reg_noce1");
    tick();
    drive(1'b0, 1'b0, 1'b0, 13'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h010, 16'd0);
    push_exp(1, 1, 16'h5678, "rd10_again");
    push_exp(4, 1, INIT_B_V, "reg_noce2");
    tick();
    drive(1'b0, 1'b0, 1'b0, 13'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h020, 16'd0);
    push_exp(1, 1, 16'hBEEF, "rd_beef");
    push_exp(4, 1, 16'h5678, "reg_edge1_prev");
    push_exp(4, 2, 16'hBEEF, "reg_edge2_beef");
    tick();
    drive(1'b0, 1'b0, 1'b0, 13'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 16'd0);
    push_exp(1, 1, 16'hBEEF, "dob_en0_hold");
    tick();
    drive(1'b0, 1'b0, 1'b0, 13'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h010, 16'd0);
    push_exp(4, 1, 16'hBEEF, "reg_ce0_hold");
    push_exp(1, 1, 16'h5678, "rd10_third");
    tick();
    drive(1'b0, 1'b0, 1'b0, 13'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 16'd0);
    push_exp(4, 1, SRVAL_B_V, "reg_ssr");
    push_exp(1, 1, 16'h5678, "ssr_en0_hold");
    tick();
    drive(1'b0, 1'b0, 1'b0, 13'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 16'd0);
    push_exp(4, 1, 16'h5678, "reg_latch_kept");
    tick();
    drive(1'b0, 1'b0, 1'b0, 13'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h010, 16'd0);
    push_exp(1, 1, SRVAL_B_V, "ssr_dob");
    tick();

    // Collision: both ports write word 0 in the same cycle; B wins.
    drive(1'b1, 1'b1, 1'b0, 13'd0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 16'h0000);
    coll_next = 1'b1;
    push_exp(0, 1, 16'h0003, "coll_doa_wf");
    push_exp(1, 1, 16'h0000, "coll_dob_wf");
    tick();
    drive(1'b0, 1'b0, 1'b0, 13'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 16'd0);
    push_exp(1, 1, 16'h0000, "coll_b_wins");
    tick();
    drive(1'b1, 1'b0, 1'b0, 13'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 16'd0);
    push_exp(0, 1, 16'h0000, "coll_a0_zero");
    tick();

    // Cross read/write: A reads word 0 while B writes FFFF over it.
    drive(1'b1, 1'b0, 1'b0, 13'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 16'hFFFF);
    coll_next = 1'b1;
    push_exp(0, 1, 16'h0000, "cross_old");
    push_exp(1, 1, 16'hFFFF, "cross_dob_wf");
    tick();
    drive(1'b1, 1'b0, 1'b0, 13'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 16'd0);
    push_exp(0, 1, 16'h0003, "cross_new");
    tick();

    // Port A synchronous set/reset.
    drive(1'b1, 1'b0, 1'b1, 13'd5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 16'd0);
    push_exp(0, 1, {14'b0, SRVAL_A_V}, "ssr_doa");
    tick();

    idle();
    repeat (3) tick();
    #1;

    // Any expectation still queued was never compared.
    foreach (exp_q[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain %s: never compared, expected %h", exp_q[i].name, exp_q[i].val);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
